// File: rtl/led_ctrl_if.sv
// ----------------------------------------------------------------------------
// led_ctrl_if : PicoSoC iomem bus bundle between the CPU side (master) and a
//               memory-mapped peripheral (slave).
//   iomem_valid  master -> slave  request valid
//   iomem_ready  slave  -> master one-cycle acknowledge
//   iomem_wstrb  master -> slave  byte write strobes, 0 = read
//   iomem_addr   master -> slave  byte address
//   iomem_wdata  master -> slave  write data
//   iomem_rdata  slave  -> master read data, valid while iomem_ready = 1
// ----------------------------------------------------------------------------
interface led_ctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/led_ctrl.sv
// ----------------------------------------------------------------------------
// led_ctrl : memory-mapped LED controller, sole driver of the 8 board LEDs.
//   Sources: free-running heartbeat counter, static CPU value, or per-LED
//   8-bit PWM dimming. The heartbeat runs out of reset without firmware.
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     iomem slave port (valid/ready/wstrb/addr/wdata/rdata)
//   leds    registered active-high LED drive
// Register map (byte offset in the 256-byte window at ADDR_BASE):
//   0x00 CTRL[1:0] mode   0x04 STATIC[7:0]   0x08 DUTY_LO   0x0C DUTY_HI
//   0x10 PRESCALE[15:0]   0x14 STATUS (ro: [7:0] pwm_cnt, [8] tick)
// ----------------------------------------------------------------------------
module led_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'h0300_0000,
  parameter int          CNT_W     = 24
) (
  input  logic       clk,
  input  logic       resetn,
  led_ctrl_if.slave  bus,
  output logic [7:0] leds
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATIC = 8'h04;
  localparam logic [7:0] OFF_DUTYLO = 8'h08;
  localparam logic [7:0] OFF_DUTYHI = 8'h0C;
  localparam logic [7:0] OFF_PRESC  = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  logic [0:0]       state_q, state_d;
  logic             ready_q;
  logic [31:0]      rdata_q, rd_val;
  logic [1:0]       mode_q;
  logic [7:0]       static_q;
  logic [31:0]      duty_lo_q, duty_hi_q;
  logic [15:0]      prescale_q;
  logic [15:0]      presc_q, presc_d;
  logic [7:0]       pwm_cnt_q;
  logic [CNT_W-1:0] hb_q;
  logic [7:0]       leds_q, leds_d;
  logic [63:0]      duty_all;
  logic             sel, access, wr_en, tick;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Window decode: only the upper 24 address bits select this block.
  assign sel    = bus.iomem_valid && (bus.iomem_addr[31:8] == ADDR_BASE[31:8]);
  assign access = (state_q == ST_IDLE) && sel && !ready_q;
  assign wr_en  = access && (bus.iomem_wstrb != 4'b0000);

  // PWM timebase. Using >= rather than == lets a PRESCALE write below the
  // running count restart at 0 instead of wrapping through 65535.
  assign tick    = (presc_q == prescale_q);
  assign presc_d = (presc_q >= prescale_q) ? 16'd0 : presc_q + 16'd1;

  assign duty_all = {duty_hi_q, duty_lo_q};

  // NOTE: every path assigns a default first so this decode stays purely
  // combinational and never infers a latch.
  always_comb begin
    rd_val = 32'd0;
    case (bus.iomem_addr[7:0])
      OFF_CTRL:   rd_val = {30'd0, mode_q};
      OFF_STATIC: rd_val = {24'd0, static_q};
      OFF_DUTYLO: rd_val = duty_lo_q;
      OFF_DUTYHI: rd_val = duty_hi_q;
      OFF_PRESC:  rd_val = {16'd0, prescale_q};
      OFF_STATUS: rd_val = {23'd0, tick, pwm_cnt_q};
      default:    rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Mode 3 is reserved and falls back to the heartbeat.
  always_comb begin
    leds_d = hb_q[CNT_W-1 -: 8];
    case (mode_q)
      2'd1: leds_d = static_q;
      2'd2: for (int i = 0; i < 8; i++) leds_d[i] = (pwm_cnt_q < duty_all[8*i +: 8]);
      default: leds_d = hb_q[CNT_W-1 -: 8];
    endcase
  end

  // NOTE: all flops use non-blocking assignments so each one samples the
  // pre-edge value of the others regardless of statement order.
  // NOTE: everything here is plain flops (no RAM), so every register,
  // including rdata, takes the async reset and an aborted write is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      mode_q     <= 2'd0;
      static_q   <= 8'd0;
      duty_lo_q  <= 32'd0;
      duty_hi_q  <= 32'd0;
      prescale_q <= 16'd0;
      presc_q    <= 16'd0;
      pwm_cnt_q  <= 8'd0;
      hb_q       <= '0;
      leds_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_ACK);
      if (access) rdata_q <= wr_en ? 32'd0 : rd_val;

      if (wr_en) begin
        case (bus.iomem_addr[7:0])
          OFF_CTRL:   if (bus.iomem_wstrb[0]) mode_q   <= bus.iomem_wdata[1:0];
          OFF_STATIC: if (bus.iomem_wstrb[0]) static_q <= bus.iomem_wdata[7:0];
          OFF_DUTYLO: duty_lo_q <= merge_bytes(duty_lo_q, bus.iomem_wdata, bus.iomem_wstrb);
          OFF_DUTYHI: duty_hi_q <= merge_bytes(duty_hi_q, bus.iomem_wdata, bus.iomem_wstrb);
          OFF_PRESC: begin
            if (bus.iomem_wstrb[0]) prescale_q[7:0]  <= bus.iomem_wdata[7:0];
            if (bus.iomem_wstrb[1]) prescale_q[15:8] <= bus.iomem_wdata[15:8];
          end
          default: ;
        endcase
      end

      // Counters free-run independent of bus traffic.
      hb_q    <= hb_q + CNT_W'(1);
      presc_q <= presc_d;
      if (tick) pwm_cnt_q <= pwm_cnt_q + 8'd1;
      leds_q  <= leds_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign leds            = leds_q;

endmodule

// File: tb/tb_led_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_ctrl : directed bench for led_ctrl (CNT_W = 8). Bus reads push their
// expected data into a scoreboard queue; a monitor pops and compares each
// time the DUT acknowledges. LED and timing checks are made inline.
// ----------------------------------------------------------------------------
module tb_led_ctrl;

  localparam logic [31:0] BASE     = 32'h0300_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_STATIC = BASE + 32'h04;
  localparam logic [31:0] A_DUTYLO = BASE + 32'h08;
  localparam logic [31:0] A_DUTYHI = BASE + 32'h0C;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;
  localparam logic [31:0] A_STATUS = BASE + 32'h14;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] leds;

  led_ctrl_if bus ();

  led_ctrl #(.ADDR_BASE(BASE), .CNT_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .leds   (leds)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every acknowledge consumes one scoreboard entry.
  always @(negedge clk) begin
    if (resetn && bus.iomem_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: ready=1 with no access pending (t=%0t)", $time);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.chk) check(e.name, bus.iomem_rdata, e.exp);
      end
    end
  end

  // One access: valid rises #1 after a posedge, ready must follow exactly one
  // cycle later. The bound on the wait keeps the bench from hanging.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic chk,
                          input logic [31:0] exp, input string name,
                          output logic [31:0] rdata);
    sb_t e;
    int  lat;
    e.name = name; e.chk = chk; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wdata = wdata;
    bus.iomem_wstrb = wstrb;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.iomem_ready && lat < 4);
    rdata = bus.iomem_rdata;
    check({name, "_latency"}, 32'(lat), 32'd1);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input string name);
    logic [31:0] dummy;
    bus_xfer(addr, data, strb, 1'b0, 32'd0, name, dummy);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] dummy;
    bus_xfer(addr, 32'd0, 4'b0000, 1'b1, exp, name, dummy);
  endtask

  task automatic rd_nc(input logic [31:0] addr, output logic [31:0] data);
    bus_xfer(addr, 32'd0, 4'b0000, 1'b0, 32'd0, "sync_read", data);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] st;
    logic [7:0]  c0, c1;
    int          on_cnt[8];
    int          exp_on[8];
    int          tries;
    int          seen;

    exp_on = '{64, 128, 255, 0, 0, 0, 0, 0};

    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    bus.iomem_addr  = 32'd0;
    bus.iomem_wdata = 32'd0;
    resetn = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds",  {24'd0, leds}, 32'd0);
    check("rst_ready", {31'd0, bus.iomem_ready}, 32'd0);
    check("rst_rdata", bus.iomem_rdata, 32'd0);

    // Heartbeat: 0,1,2,... one step per cycle, wrapping 255 -> 0.
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("heartbeat", {24'd0, leds}, {24'd0, 8'(i)});
    end

    // Static mode and register readback.
    wr(A_CTRL,   32'h0000_0001, 4'b0001, "wr_ctrl1");
    wr(A_STATIC, 32'h0000_00A5, 4'b0001, "wr_static");
    @(posedge clk);
    @(negedge clk);
    check("static_leds", {24'd0, leds}, 32'h0000_00A5);
    rd(A_STATIC, 32'h0000_00A5, "rd_static");
    wr(A_STATIC, 32'hFFFF_FF3C, 4'b0010, "wr_static_b1");
    rd(A_STATIC, 32'h0000_00A5, "rd_static_strobe");
    wr(A_CTRL,   32'hFFFF_FFFF, 4'b1111, "wr_ctrl_all");
    rd(A_CTRL,   32'h0000_0003, "rd_ctrl_reserved");

    // PWM duty with a tick every cycle.
    wr(A_PRESC,  32'h0000_0000, 4'b0011, "wr_presc0");
    wr(A_DUTYLO, 32'h00FF_8040, 4'b1111, "wr_duty_lo");
    wr(A_DUTYHI, 32'h0000_0000, 4'b1111, "wr_duty_hi");
    rd(A_DUTYLO, 32'h00FF_8040, "rd_duty_lo");
    wr(A_CTRL,   32'h0000_0002, 4'b0001, "wr_ctrl_pwm");
    @(posedge clk);
    for (int i = 0; i < 8; i++) on_cnt[i] = 0;
    for (int s = 0; s < 256; s++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if (leds[i]) on_cnt[i]++;
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("pwm_on_led%0d", i), 32'(on_cnt[i]), 32'(exp_on[i]));

    // PRESCALE=3: find a tick, then confirm the 4-cycle period.
    wr(A_PRESC, 32'h0000_0003, 4'b0011, "wr_presc3");
    tries = 0;
    rd_nc(A_STATUS, st);
    while (!st[8] && tries < 16) begin
      tries++;
      @(posedge clk);
      rd_nc(A_STATUS, st);
    end
    check("status_tick_found", {31'd0, st[8]}, 32'd1);
    c0 = st[7:0];
    rd(A_STATUS, {23'd0, 1'b0, 8'(c0 + 8'd1)}, "status_p4_t2");
    rd(A_STATUS, {23'd0, 1'b1, 8'(c0 + 8'd1)}, "status_p4_t4");
    c1 = c0 + 8'd1;

    // Shrink PRESCALE under the running count: restart, then period 2.
    wr(A_PRESC, 32'h0000_0001, 4'b0011, "wr_presc1");
    rd(A_STATUS, {23'd0, 1'b0, 8'(c1 + 8'd1)}, "status_restart");
    @(posedge clk);
    rd(A_STATUS, {23'd0, 1'b1, 8'(c1 + 8'd2)}, "status_p2_a");
    rd(A_STATUS, {23'd0, 1'b1, 8'(c1 + 8'd3)}, "status_p2_b");

    // Unused offset in the window, then an address outside it.
    rd(BASE + 32'h20, 32'd0, "rd_unused_off");
    @(posedge clk); #1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0400_0000;
    bus.iomem_wstrb = 4'b0000;
    seen = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (bus.iomem_ready) seen++;
    end
    check("out_of_window_ready", 32'(seen), 32'd0);
    bus.iomem_valid = 1'b0;

    // Reset during a DUTY write: no ack, write lost, LEDs clear at once.
    wr(A_CTRL,   32'h0000_0001, 4'b0001, "wr_ctrl_static");
    wr(A_STATIC, 32'h0000_00FF, 4'b0001, "wr_static_ff");
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_leds", {24'd0, leds}, 32'h0000_00FF);
    @(posedge clk); #1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = A_DUTYLO;
    bus.iomem_wdata = 32'h1234_5678;
    bus.iomem_wstrb = 4'b1111;
    resetn = 1'b0;
    #1;
    check("midrst_leds",  {24'd0, leds}, 32'd0);
    check("midrst_ready", {31'd0, bus.iomem_ready}, 32'd0);
    @(posedge clk); #1;
    check("midrst_ready_edge", {31'd0, bus.iomem_ready}, 32'd0);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    @(negedge clk) resetn = 1'b1;
    rd(A_DUTYLO, 32'd0, "rd_duty_after_rst");
    rd(A_CTRL,   32'd0, "rd_ctrl_after_rst");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
